// File: rtl/run_monitor_if.sv
// run_monitor_if: tap bundle between the core and run_monitor.
// master = core/bench side that drives the taps, slave = the monitor.
interface run_monitor_if #(
    parameter int CNT_W = 64,
    parameter int DEPTH = 16
) ();
    localparam int AW = $clog2(DEPTH);

    logic             ecall_pulse;
    logic             ebreak_pulse;
    logic             wb_wen;
    logic [4:0]       wb_rd_addr;
    logic [31:0]      wb_data;
    logic [31:0]      wb_pc;
    logic             clear;
    logic             halted;
    logic [1:0]       halt_cause;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] retire_count;
    logic [AW:0]      trace_count;
    logic [AW-1:0]    rd_idx;
    logic             rd_valid;
    logic [4:0]       rd_rd;
    logic [31:0]      rd_data;
    logic [31:0]      rd_pc;

    modport master (
        output ecall_pulse, ebreak_pulse, wb_wen, wb_rd_addr, wb_data, wb_pc,
               clear, rd_idx,
        input  halted, halt_cause, cycle_count, retire_count, trace_count,
               rd_valid, rd_rd, rd_data, rd_pc
    );

    modport slave (
        input  ecall_pulse, ebreak_pulse, wb_wen, wb_rd_addr, wb_data, wb_pc,
               clear, rd_idx,
        output halted, halt_cause, cycle_count, retire_count, trace_count,
               rd_valid, rd_rd, rd_data, rd_pc
    );
endinterface

// File: rtl/run_monitor.sv
// run_monitor: run/halt control, cycle and retire counters, and a ring
// buffer of the last DEPTH register writebacks readable after halt.
// Optional feature macro: RUN_MONITOR_TIMEOUT_EN enables the cycle-budget halt.
//
//  state  | meaning
//  S_RUN  | counting cycles, logging writebacks, watching for halt events
//  S_HALT | everything frozen; waits for clear
module run_monitor #(
    parameter int CNT_W   = 64,
    parameter int TIMEOUT = 100,
    parameter int DEPTH   = 16
) (
    input logic          clk,
    input logic          rst,
    run_monitor_if.slave mon
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      DEPTH_C    = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] TIMEOUT_TC = CNT_W'(TIMEOUT - 1);
`ifdef RUN_MONITOR_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    typedef enum logic {S_RUN, S_HALT} state_t;

    state_t           state_q, state_d;
    logic [1:0]       cause_q, cause_d;
    logic             running;
    logic             restart;
    logic             log_wb;
    logic             timeout_hit;
    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] retire_q;
    logic [AW:0]      tcount_q;
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rd_addr;
    logic [68:0]      mem [DEPTH];
    logic             rv_q;
    logic [4:0]       rrd_q;
    logic [31:0]      rdata_q;
    logic [31:0]      rpc_q;

    // With the feature off the compare folds to constant 0 and disappears.
    assign timeout_hit = TIMEOUT_EN && (cycle_q == TIMEOUT_TC);
    assign log_wb      = running && mon.wb_wen && (mon.wb_rd_addr != 5'd0);
    assign rd_addr     = wptr_q - AW'(1) - mon.rd_idx;

    // State register and latched halt cause.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RUN;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    // Next-state logic: halt priority is ECALL, EBREAK, then timeout.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        running = 1'b0;
        restart = 1'b0;
        case (state_q)
            S_RUN: begin
                running = 1'b1;
                if (mon.ecall_pulse) begin
                    state_d = S_HALT;
                    cause_d = 2'b01;
                end else if (mon.ebreak_pulse) begin
                    state_d = S_HALT;
                    cause_d = 2'b10;
                end else if (timeout_hit) begin
                    state_d = S_HALT;
                    cause_d = 2'b11;
                end
            end
            S_HALT: begin
                if (mon.clear) begin
                    state_d = S_RUN;
                    cause_d = 2'b00;
                    restart = 1'b1;
                end
            end
            default: begin
                state_d = S_RUN;
                cause_d = 2'b00;
            end
        endcase
    end

    // Counters and write pointer; the halting cycle itself is still counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_q  <= '0;
            retire_q <= '0;
            tcount_q <= '0;
            wptr_q   <= '0;
        end else if (restart) begin
            cycle_q  <= '0;
            retire_q <= '0;
            tcount_q <= '0;
            wptr_q   <= '0;
        end else if (running) begin
            cycle_q <= cycle_q + CNT_W'(1);
            if (log_wb) begin
                retire_q <= retire_q + CNT_W'(1);
                wptr_q   <= wptr_q + AW'(1);
                if (tcount_q != DEPTH_C)
                    tcount_q <= tcount_q + (AW+1)'(1);
            end
        end
    end

    // Trace storage; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (log_wb)
            mem[wptr_q] <= {mon.wb_rd_addr, mon.wb_data, mon.wb_pc};
    end

    // Registered trace read; a same-edge write to this slot returns the old entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rv_q    <= 1'b0;
            rrd_q   <= '0;
            rdata_q <= '0;
            rpc_q   <= '0;
        end else if ({1'b0, mon.rd_idx} < tcount_q) begin
            rv_q    <= 1'b1;
            rrd_q   <= mem[rd_addr][68:64];
            rdata_q <= mem[rd_addr][63:32];
            rpc_q   <= mem[rd_addr][31:0];
        end else begin
            rv_q    <= 1'b0;
            rrd_q   <= '0;
            rdata_q <= '0;
            rpc_q   <= '0;
        end
    end

    assign mon.halted       = (state_q == S_HALT);
    assign mon.halt_cause   = cause_q;
    assign mon.cycle_count  = cycle_q;
    assign mon.retire_count = retire_q;
    assign mon.trace_count  = tcount_q;
    assign mon.rd_valid     = rv_q;
    assign mon.rd_rd        = rrd_q;
    assign mon.rd_data      = rdata_q;
    assign mon.rd_pc        = rpc_q;
endmodule

// File: tb/tb_run_monitor.sv
// tb_run_monitor: table vectors, directed corner sequences and random
// stimulus against a queue-based reference model of run_monitor.
module tb_run_monitor;
    localparam int CNT_W   = 64;
    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 100;
`ifdef RUN_MONITOR_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    run_monitor_if #(.CNT_W(CNT_W), .DEPTH(DEPTH)) bus ();

    run_monitor #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .mon (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a newest-first list of trace entries plus counters.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] pc;
    } ent_t;

    ent_t            q[$];
    bit              m_halted;
    logic [1:0]      m_cause;
    longint unsigned m_cyc;
    longint unsigned m_ret;
    logic            m_rv;
    logic [4:0]      m_rd;
    logic [31:0]     m_data;
    logic [31:0]     m_pc;

    task automatic model_reset();
        q.delete();
        m_halted = 0; m_cause = 2'b00; m_cyc = 0; m_ret = 0;
        m_rv = 0; m_rd = 0; m_data = 0; m_pc = 0;
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        longint unsigned old_cyc;
        ent_t e;
        if (int'(bus.rd_idx) < q.size()) begin
            m_rv = 1; m_rd = q[bus.rd_idx].rd; m_data = q[bus.rd_idx].data; m_pc = q[bus.rd_idx].pc;
        end else begin
            m_rv = 0; m_rd = 0; m_data = 0; m_pc = 0;
        end
        if (!m_halted) begin
            old_cyc = m_cyc;
            m_cyc   = m_cyc + 1;
            if (bus.wb_wen && bus.wb_rd_addr != 0) begin
                e.rd = bus.wb_rd_addr; e.data = bus.wb_data; e.pc = bus.wb_pc;
                q.push_front(e);
                if (q.size() > DEPTH) void'(q.pop_back());
                m_ret = m_ret + 1;
            end
            if (bus.ecall_pulse) begin
                m_halted = 1; m_cause = 2'b01;
            end else if (bus.ebreak_pulse) begin
                m_halted = 1; m_cause = 2'b10;
            end else if (TO_EN && old_cyc == longint'(TIMEOUT - 1)) begin
                m_halted = 1; m_cause = 2'b11;
            end
        end else if (bus.clear) begin
            m_halted = 0; m_cause = 2'b00; m_cyc = 0; m_ret = 0;
            q.delete();
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".halted"}, 64'(bus.halted), 64'(m_halted));
        chk({tag, ".cause"}, 64'(bus.halt_cause), 64'(m_cause));
        chk({tag, ".cycle"}, bus.cycle_count, m_cyc);
        chk({tag, ".retire"}, bus.retire_count, m_ret);
        chk({tag, ".tcount"}, 64'(bus.trace_count), 64'(q.size()));
        chk({tag, ".rv"}, 64'(bus.rd_valid), 64'(m_rv));
        chk({tag, ".rd"}, 64'(bus.rd_rd), 64'(m_rd));
        chk({tag, ".data"}, 64'(bus.rd_data), 64'(m_data));
        chk({tag, ".pc"}, 64'(bus.rd_pc), 64'(m_pc));
    endtask

    task automatic drive(input logic wen, input logic [4:0] rd, input logic [31:0] data,
                         input logic [31:0] pc, input logic ec, input logic eb,
                         input logic clr, input logic [3:0] idx);
        bus.wb_wen = wen; bus.wb_rd_addr = rd; bus.wb_data = data; bus.wb_pc = pc;
        bus.ecall_pulse = ec; bus.ebreak_pulse = eb; bus.clear = clr; bus.rd_idx = idx;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;
    endtask

    typedef struct {
        logic        wen;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] pc;
        logic        ec;
        logic        eb;
        logic        clr;
        logic [3:0]  idx;
        logic        e_halt;
        logic [1:0]  e_cause;
        int          e_cyc;
        int          e_ret;
        int          e_tc;
        logic        e_rv;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vt[10];

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();

        // ECALL scenario, freeze, clear; expected values worked out by hand.
        vt[0] = '{1, 1,  32'h11, 32'h100, 0, 0, 0, 0,  0, 2'b00, 1, 1, 1,  0, 0, 32'h0,  32'h0};
        vt[1] = '{1, 2,  32'h22, 32'h104, 0, 0, 0, 0,  0, 2'b00, 2, 2, 2,  1, 1, 32'h11, 32'h100};
        vt[2] = '{1, 0,  32'h33, 32'h108, 0, 0, 0, 0,  0, 2'b00, 3, 2, 2,  1, 2, 32'h22, 32'h104};
        vt[3] = '{0, 0,  32'h0,  32'h0,   0, 0, 0, 0,  0, 2'b00, 4, 2, 2,  1, 2, 32'h22, 32'h104};
        vt[4] = '{0, 0,  32'h0,  32'h0,   1, 0, 0, 2,  1, 2'b01, 5, 2, 2,  0, 0, 32'h0,  32'h0};
        vt[5] = '{0, 0,  32'h0,  32'h0,   0, 0, 0, 1,  1, 2'b01, 5, 2, 2,  1, 1, 32'h11, 32'h100};
        vt[6] = '{0, 0,  32'h0,  32'h0,   0, 0, 0, 0,  1, 2'b01, 5, 2, 2,  1, 2, 32'h22, 32'h104};
        vt[7] = '{1, 5,  32'h55, 32'h200, 1, 1, 0, 0,  1, 2'b01, 5, 2, 2,  1, 2, 32'h22, 32'h104};
        vt[8] = '{0, 0,  32'h0,  32'h0,   0, 0, 1, 1,  0, 2'b00, 0, 0, 0,  1, 1, 32'h11, 32'h100};
        vt[9] = '{0, 0,  32'h0,  32'h0,   0, 0, 0, 0,  0, 2'b00, 1, 0, 0,  0, 0, 32'h0,  32'h0};

        repeat (2) @(posedge clk);
        #1;
        chk("reset.halted", 64'(bus.halted), 64'd0);
        chk("reset.cause", 64'(bus.halt_cause), 64'd0);
        chk("reset.cycle", bus.cycle_count, 64'd0);
        chk("reset.tcount", 64'(bus.trace_count), 64'd0);
        chk("reset.rv", 64'(bus.rd_valid), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            drive(vt[i].wen, vt[i].rd, vt[i].data, vt[i].pc, vt[i].ec, vt[i].eb, vt[i].clr, vt[i].idx);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d.halted", i), 64'(bus.halted), 64'(vt[i].e_halt));
            chk($sformatf("vec%0d.cause", i), 64'(bus.halt_cause), 64'(vt[i].e_cause));
            chk($sformatf("vec%0d.cycle", i), bus.cycle_count, 64'(vt[i].e_cyc));
            chk($sformatf("vec%0d.retire", i), bus.retire_count, 64'(vt[i].e_ret));
            chk($sformatf("vec%0d.tcount", i), 64'(bus.trace_count), 64'(vt[i].e_tc));
            chk($sformatf("vec%0d.rv", i), 64'(bus.rd_valid), 64'(vt[i].e_rv));
            chk($sformatf("vec%0d.rd", i), 64'(bus.rd_rd), 64'(vt[i].e_rd));
            chk($sformatf("vec%0d.data", i), 64'(bus.rd_data), 64'(vt[i].e_data));
            chk($sformatf("vec%0d.pc", i), 64'(bus.rd_pc), 64'(vt[i].e_pc));
        end

        // Priority: simultaneous pulses, then EBREAK alone.
        do_reset();
        drive(0, 0, 0, 0, 1, 1, 0, 0); step(); chk_model("prio_both");
        chk("prio_both.cause", 64'(bus.halt_cause), 64'd1);
        do_reset();
        drive(0, 0, 0, 0, 0, 1, 0, 0); step(); chk_model("prio_eb");
        chk("prio_eb.cause", 64'(bus.halt_cause), 64'd2);

        // Cycle budget: timeout halt, and timeout cycle coinciding with EBREAK.
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        if (TO_EN) begin
            for (int i = 0; i < TIMEOUT + 5; i++) begin step(); chk_model("to"); end
            chk("to.halted", 64'(bus.halted), 64'd1);
            chk("to.cause", 64'(bus.halt_cause), 64'd3);
            chk("to.cycle", bus.cycle_count, 64'(TIMEOUT));
            do_reset();
            for (int i = 0; i < TIMEOUT - 1; i++) begin step(); chk_model("to_eb.pre"); end
            drive(0, 0, 0, 0, 0, 1, 0, 0); step(); chk_model("to_eb");
            chk("to_eb.cause", 64'(bus.halt_cause), 64'd2);
            chk("to_eb.cycle", bus.cycle_count, 64'(TIMEOUT));
        end else begin
            for (int i = 0; i < 200; i++) begin step(); chk_model("noto"); end
            chk("noto.halted", 64'(bus.halted), 64'd0);
            chk("noto.cycle", bus.cycle_count, 64'd200);
        end

        // Ring wrap: 20 writebacks into a 16-entry trace.
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            drive(1, 5'(i), 32'(i * 16), 32'h1000 + 32'(4 * i), 0, 0, 0, 4'(i));
            step(); chk_model("wrap.wr");
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0); step(); chk_model("wrap.r0");
        chk("wrap.tcount", 64'(bus.trace_count), 64'd16);
        chk("wrap.retire", bus.retire_count, 64'd20);
        chk("wrap.idx0", 64'(bus.rd_rd), 64'd20);
        drive(0, 0, 0, 0, 0, 0, 0, 15); step(); chk_model("wrap.r15");
        chk("wrap.idx15", 64'(bus.rd_rd), 64'd5);

        // Freeze after halt, then clear.
        drive(0, 0, 0, 0, 1, 0, 0, 0); step(); chk_model("frz.halt");
        for (int i = 0; i < 10; i++) begin
            drive(1, 5'(i + 1), 32'hdead0000 + 32'(i), 32'h2000, 1'(i), 1'(~i), 0, 4'(i));
            step(); chk_model("frz");
        end
        chk("frz.cycle", bus.cycle_count, 64'd23);
        chk("frz.retire", bus.retire_count, 64'd20);
        drive(0, 0, 0, 0, 0, 0, 1, 0); step(); chk_model("clr");
        chk("clr.halted", 64'(bus.halted), 64'd0);
        chk("clr.tcount", 64'(bus.trace_count), 64'd0);

        // Asynchronous reset between edges.
        drive(1, 3, 32'h77, 32'h300, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin step(); chk_model("ar.pre"); end
        #2 rst = 1'b1;
        #1;
        chk("ar.halted", 64'(bus.halted), 64'd0);
        chk("ar.cycle", bus.cycle_count, 64'd0);
        chk("ar.retire", bus.retire_count, 64'd0);
        chk("ar.tcount", 64'(bus.trace_count), 64'd0);
        chk("ar.rv", 64'(bus.rd_valid), 64'd0);
        chk("ar.data", 64'(bus.rd_data), 64'd0);
        do_reset();

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom, $urandom,
                  1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 39) == 0),
                  1'($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)));
            step();
            chk_model("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/run_monitor.md
# run_monitor

Synthesizable run-control and trace monitor for the pipelined RISC-V core. It detects program termination from the core's ECALL/EBREAK pulses or a cycle timeout, and counts cycles and retired register writes. It also keeps a ring buffer of the last DEPTH writeback events that can be read after halt. It sits beside `top` and taps the writeback and ID-stage halt signals, so benches and FPGA debug logic no longer need a free-running testbench loop.

## Interface
- `CNT_W`, 64: width of cycle and retire counters.
- `TIMEOUT`, 100: cycle budget before forced halt; must be ≥1 and < 2^CNT_W.
- `DEPTH`, 16: trace entries; power of two, ≥2. `AW = $clog2(DEPTH)`.

Ports:
- `clk`  in  1  core clock.
- `rst`  in  1  asynchronous, active-high reset.
- `ecall_pulse`  in  1  one-cycle ECALL indication from core.
- `ebreak_pulse`  in  1  one-cycle EBREAK indication from core.
- `wb_wen`  in  1  final writeback enable.
- `wb_rd_addr`  in  5  writeback destination register.
- `wb_data`  in  32  writeback data.
- `wb_pc`  in  32  PC of the writing instruction.
- `clear`  in  1  restart monitoring; honoured only in HALT.
- `halted`  out  1  high in HALT state.
- `halt_cause`  out  2  00 none, 01 ECALL, 10 EBREAK, 11 timeout.
- `cycle_count`  out  CNT_W  cycles spent in RUN.
- `retire_count`  out  CNT_W  logged writebacks (rd≠0).
- `trace_count`  out  AW+1  valid trace entries, saturating at DEPTH.
- `rd_idx`  in  AW  trace read index; 0 = most recent entry.
- `rd_valid`  out  1  registered: entry at the sampled `rd_idx` exists.
- `rd_rd`  out  5  registered trace entry rd.
- `rd_data`  out  32  registered trace entry data.
- `rd_pc`  out  32  registered trace entry PC.

## Operation
- Two states: RUN and HALT. Reset enters RUN.
- Reset values: `halted`=0, `halt_cause`=00, all counters 0, write pointer 0, `rd_valid`=0, `rd_rd`/`rd_data`/`rd_pc`=0. Trace RAM contents are not reset.
- In RUN, every cycle:
  - `cycle_count` increments.
  - If `wb_wen` is high and `wb_rd_addr`≠0: write {rd, data, pc} at the write pointer, advance the pointer modulo DEPTH, increment `retire_count`, and increment `trace_count` if it is below DEPTH.
- RUN→HALT transitions, in priority order:
  - `ecall_pulse` → cause 01.
  - else `ebreak_pulse` → cause 10.
  - else `cycle_count`==TIMEOUT−1 → cause 11.
- The halting cycle itself is still counted and its writeback is still logged.
- In HALT:
  - All counters, the pointer and the trace are frozen. Core inputs are ignored.
  - `clear` → RUN next cycle, with counters, pointer and `trace_count` zeroed and cause 00.
- `clear` in RUN has no effect.
- Trace read: entry address = (wptr − 1 − `rd_idx`) mod DEPTH. `rd_valid` = (`rd_idx` < `trace_count`). Reads are permitted in any state. When `rd_valid`=0, the data outputs read 0.
- Asserting `rst` mid-run returns to the reset values immediately, regardless of state.

## Timing
- `halted` and `halt_cause` rise on the clock edge that samples the terminating condition. They are valid in the next cycle.
- `cycle_count` equals the number of RUN edges seen. After a timeout halt, `cycle_count`==TIMEOUT.
- Trace read latency is 1 cycle: `rd_idx` is sampled at an edge and the outputs are valid after that edge.
- A same-cycle trace write and read at the same address returns the old entry.
- Counter overflow wraps modulo 2^CNT_W. `trace_count` saturates at DEPTH and never wraps.

## Configuration
- `RUN_MONITOR_TIMEOUT_EN`:
  - Defined: timeout halt behaves as described above.
  - Undefined: the timeout comparator is removed. Cause 11 is never produced, `TIMEOUT` is ignored, and `cycle_count` runs until ECALL/EBREAK, wrapping if needed.

## Test plan
- ECALL: reset, 3 writebacks (x1=0x11 @pc 0x100, x2=0x22 @0x104, x0=0x33 @0x108), then `ecall_pulse` on cycle 5 → `halted`=1, cause 01, `cycle_count`=5, `retire_count`=2, `trace_count`=2; `rd_idx`=0 → rd=2/0x22/0x104; `rd_idx`=2 → `rd_valid`=0.
- Priority: `ecall_pulse` and `ebreak_pulse` in the same cycle → cause 01. An EBREAK pulse alone → cause 10.
- Timeout (macro defined, TIMEOUT=100): no pulses → halt with cause 11 and `cycle_count`=100. Timeout cycle coinciding with `ebreak_pulse` → cause 10. With the macro undefined, 200 cycles pass with `halted`=0.
- Wrap (DEPTH=16): 20 writebacks to x1..x20 → `trace_count`=16, `retire_count`=20; `rd_idx`=0 → x20; `rd_idx`=15 → x5.
- Clear/freeze: after halt, 10 writebacks and pulses are injected → no counter or trace change. Pulse `clear` → next cycle `halted`=0, counters 0, `trace_count`=0.
- Async reset mid-run: `rst` asserted between clock edges → outputs reach their reset values before the next edge.
